// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared encodings for the RV32I multi-cycle control unit
package rv32i_pkg;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
    ALU_SUB = 4'b1000, ALU_SRA = 4'b1101
  } alu_op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;
  typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_FENCE} cls_e;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] PC_4    = 2'b00;
  localparam logic [1:0] PC_IMM  = 2'b01;
  localparam logic [1:0] PC_ALU  = 2'b10;
  localparam logic [1:0] SRC_RS1 = 2'b00;
  localparam logic [1:0] SRC_PC  = 2'b01;
  localparam logic [1:0] SRC_ZERO = 2'b10;
endpackage

// File: rtl/rv32i_decode.sv
// rv32i_decode: combinational RV32I decoder to class, ALU op, immediate type and illegal flag
module rv32i_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_i,
  output cls_e        cls_o,
  output alu_op_e     alu_o,
  output imm_e        imm_o,
  output logic        illegal_o
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic unused_ok;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign unused_ok = ^{instr_i[24:15], instr_i[11:7]};
  // opcode-driven decode; I-ALU only takes bit 3 from instr[30] for the right shifts
  always_comb begin
    cls_o = C_R;
    alu_o = ALU_ADD;
    imm_o = IMM_I;
    illegal_o = 1'b0;
    case (op)
      OP_R: begin
        cls_o = C_R;
        alu_o = alu_op_e'({f7[5], f3});
        illegal_o = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_IMM: begin
        cls_o = C_I;
        alu_o = alu_op_e'({f3 == 3'b101 && f7[5], f3});
        illegal_o = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_LOAD: begin
        cls_o = C_LOAD;
        illegal_o = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        cls_o = C_STORE;
        imm_o = IMM_S;
        illegal_o = f3 > 3'b010;
      end
      OP_BRANCH: begin
        cls_o = C_BR;
        imm_o = IMM_B;
        illegal_o = f3[2:1] == 2'b01;
      end
      OP_JAL: begin
        cls_o = C_JAL;
        imm_o = IMM_J;
      end
      OP_JALR: begin
        cls_o = C_JALR;
        illegal_o = f3 != 3'b000;
      end
      OP_LUI: begin
        cls_o = C_LUI;
        imm_o = IMM_U;
      end
      OP_AUIPC: begin
        cls_o = C_AUIPC;
        imm_o = IMM_U;
      end
      OP_FENCE: cls_o = C_FENCE;
      OP_SYSTEM: illegal_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv32i_multicycle_control.sv
// rv32i_multicycle_control: multi-cycle FSM sequencing fetch, decode, execute, memory and writeback
module rv32i_multicycle_control
  import rv32i_pkg::*;
#(
  parameter int ALU_CTRL_W    = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  br_cond,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  imem_req,
  output logic                  ir_load,
  output logic                  dmem_req,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [2:0]            mem_size,
  output logic                  register_write_en,
  output logic [ALU_CTRL_W-1:0] alu_control_en,
  output logic [1:0]            alu_src_a,
  output logic                  imm_en,
  output logic [2:0]            imm_type,
  output logic [1:0]            wb_sel,
  output logic                  pc_write_en,
  output logic [1:0]            pc_src,
  output logic                  illegal_instr,
  output logic [2:0]            state_o
);
  state_e  state_q, state_d;
  cls_e    cls_q, d_cls;
  alu_op_e alu_q, d_alu;
  imm_e    imm_q, d_imm;
  logic [2:0] f3_q;
  logic d_ill, if_done, dm_done;
  assign if_done = imem_ready || !MEM_HANDSHAKE;
  assign dm_done = dmem_ready || !MEM_HANDSHAKE;
  assign state_o = state_q;
  rv32i_decode u_decode (
    .instr_i  (instr),
    .cls_o    (d_cls),
    .alu_o    (d_alu),
    .imm_o    (d_imm),
    .illegal_o(d_ill)
  );
  // next-state selection; TRAP only leaves through reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = if_done ? S_DECODE : S_FETCH;
      S_DECODE: state_d = d_ill ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = (cls_q inside {C_LOAD, C_STORE}) ? S_MEM :
                          (cls_q inside {C_BR, C_FENCE}) ? S_FETCH : S_WB;
      S_MEM:    state_d = !dm_done ? S_MEM : (cls_q == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
  end
  // state register plus decode fields captured once per instruction in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_R;
      alu_q   <= ALU_ADD;
      imm_q   <= IMM_I;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= d_cls;
        alu_q <= d_alu;
        imm_q <= d_imm;
        f3_q  <= instr[14:12];
      end
    end
  end
  // outputs from current state and captured fields; everything idles at zero
  always_comb begin
    imem_req = 1'b0;
    ir_load = 1'b0;
    dmem_req = 1'b0;
    mem_read_en = 1'b0;
    mem_write_en = 1'b0;
    mem_size = 3'b000;
    register_write_en = 1'b0;
    alu_control_en = '0;
    alu_src_a = SRC_RS1;
    imm_en = 1'b0;
    imm_type = IMM_I;
    wb_sel = WB_ALU;
    pc_write_en = 1'b0;
    pc_src = PC_4;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load = if_done;
      end
      S_EXEC: begin
        alu_control_en = ALU_CTRL_W'(alu_q);
        alu_src_a = (cls_q == C_LUI) ? SRC_ZERO : (cls_q inside {C_AUIPC, C_JAL}) ? SRC_PC : SRC_RS1;
        imm_en = !(cls_q inside {C_R, C_BR, C_FENCE});
        imm_type = imm_q;
        pc_write_en = cls_q inside {C_BR, C_FENCE};
        pc_src = (cls_q == C_BR && br_cond) ? PC_IMM : PC_4;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        mem_read_en = cls_q == C_LOAD;
        mem_write_en = cls_q == C_STORE;
        mem_size = f3_q;
        imm_type = imm_q;
        pc_write_en = cls_q == C_STORE && dm_done;
      end
      S_WB: begin
        register_write_en = 1'b1;
        pc_write_en = 1'b1;
        imm_type = imm_q;
        wb_sel = (cls_q == C_LOAD) ? WB_MEM : (cls_q inside {C_JAL, C_JALR}) ? WB_PC4 : WB_ALU;
        pc_src = (cls_q == C_JAL) ? PC_IMM : (cls_q == C_JALR) ? PC_ALU : PC_4;
      end
      S_TRAP: illegal_instr = 1'b1;
      default: ;
    endcase
  end
endmodule
